// File: rtl/gpr_sb_pkg.sv
// Shared widths and scoreboard state encoding for the GPR file with pending-write tracking.
// The two width constants mirror the core-wide ISA and register-index widths.
package gpr_sb_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_BUSY = 1'b1
    } pend_state_e;

endpackage

// File: rtl/gpr_sb_array.sv
// Register storage: one synchronous write port, NUM_RD combinational read ports, async-reset to 0.
// Read latency 0 cycles, write visible after the edge; no backpressure.
module gpr_sb_array #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_dat,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_dat
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_dat[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/gpr_sb.sv
// GPR file with x0 masking, optional write-to-read bypass and a per-register pending-write scoreboard.
// Read latency 0 cycles; issue stalls (iss_ready=0) while the destination has an unsatisfied older write.
module gpr_sb
    import gpr_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = ISA_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gpr_w_en,
    input  logic [ADDR_WIDTH-1:0]        gpr_w_addr,
    input  logic [DATA_WIDTH-1:0]        gpr_w,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] gpr_r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] gpr_r,
    output logic [NUM_RD-1:0]            gpr_r_busy,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    output logic                         iss_ready,
    input  logic                         flush
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]             pending_q;
    logic [DEPTH-1:0]             pending_d;
    logic                         wr_vld;
    logic                         iss_acc;
    logic [NUM_RD*DATA_WIDTH-1:0] arr_r;
    logic [ADDR_WIDTH-1:0]        rd_addr_k;

    assign wr_vld = gpr_w_en && (gpr_w_addr != '0);

    // A same-cycle write to the reserved index retires the older producer, so the new one may issue.
    assign iss_ready = !pending_q[iss_addr] || (iss_addr == '0)
                       || (gpr_w_en && (gpr_w_addr == iss_addr));
    assign iss_acc   = iss_en && iss_ready && (iss_addr != '0);

    gpr_sb_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_vld),
        .wr_addr (gpr_w_addr),
        .wr_dat  (gpr_w),
        .rd_addr (gpr_r_addr),
        .rd_dat  (arr_r)
    );

    // Order matters: write clears, a new reservation re-sets, flush overrides both.
    always_comb begin
        pending_d = pending_q;
        if (wr_vld) begin
            pending_d[gpr_w_addr] = logic'(PEND_IDLE);
        end
        if (iss_acc) begin
            pending_d[iss_addr] = logic'(PEND_BUSY);
        end
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = logic'(PEND_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Bypass is gated by reset so every port reads zero while the file is held in reset.
    always_comb begin
        gpr_r      = '0;
        gpr_r_busy = '0;
        rd_addr_k  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_k = gpr_r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (rd_addr_k == '0) begin
                gpr_r[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                gpr_r_busy[k]                     = 1'b0;
            end else if ((BYPASS != 0) && rst && gpr_w_en && (gpr_w_addr == rd_addr_k)) begin
                gpr_r[k*DATA_WIDTH +: DATA_WIDTH] = gpr_w;
                gpr_r_busy[k]                     = 1'b0;
            end else begin
                gpr_r[k*DATA_WIDTH +: DATA_WIDTH] = arr_r[k*DATA_WIDTH +: DATA_WIDTH];
                gpr_r_busy[k]                     = pending_q[rd_addr_k];
            end
        end
    end

endmodule

// File: tb/tb_gpr_sb.sv
// Directed bench: a 4-port bypassing instance and a 2-port non-bypassing instance share all stimulus.
module tb_gpr_sb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         w_en = 1'b0;
    logic [4:0]   w_addr = '0;
    logic [31:0]  w_dat = '0;
    logic [19:0]  ra = '0;
    logic         iss_en = 1'b0;
    logic [4:0]   iss_addr = '0;
    logic         flush = 1'b0;

    logic [127:0] r4;
    logic [3:0]   busy4;
    logic         rdy4;
    logic [63:0]  r2;
    logic [1:0]   busy2;
    logic         rdy2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpr_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(4), .BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .gpr_w_en   (w_en),
        .gpr_w_addr (w_addr),
        .gpr_w      (w_dat),
        .gpr_r_addr (ra),
        .gpr_r      (r4),
        .gpr_r_busy (busy4),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .iss_ready  (rdy4),
        .flush      (flush)
    );

    gpr_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(0)) dut_nb (
        .clk        (clk),
        .rst        (rst),
        .gpr_w_en   (w_en),
        .gpr_w_addr (w_addr),
        .gpr_w      (w_dat),
        .gpr_r_addr (ra[9:0]),
        .gpr_r      (r2),
        .gpr_r_busy (busy2),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .iss_ready  (rdy2),
        .flush      (flush)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en   = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    function automatic logic [19:0] pk(input logic [4:0] a3, input logic [4:0] a2,
                                       input logic [4:0] a1, input logic [4:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        // Reset, with a write attempted during reset that must not show through.
        #1 rst = 1'b0;
        #2;
        ra = pk(5'd4, 5'd3, 5'd2, 5'd1);
        w_en = 1'b1; w_addr = 5'd3; w_dat = 32'hFF;
        #1;
        chk("rst_rd4", r4, 128'h0);
        chk("rst_busy", 128'(busy4), 128'h0);
        chk("rst_rdy", 128'(rdy4), 128'h1);
        idle();
        step();
        rst = 1'b1;
        step();
        for (int a = 1; a < 32; a++) begin
            ra = pk(5'(a), 5'(a), 5'(a), 5'(a));
            #1;
            chk("post_rst_rd", r4, 128'h0);
            chk("post_rst_busy", 128'(busy4), 128'h0);
        end
        chk("post_rst_rdy", 128'(rdy4), 128'h1);

        // x0 write and reservation are ignored.
        ra = '0;
        w_en = 1'b1; w_addr = 5'd0; w_dat = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        chk("x0_byp_rd", r4, 128'h0);
        chk("x0_rdy", 128'(rdy4), 128'h1);
        step();
        idle();
        #1;
        chk("x0_rd", r4, 128'h0);
        chk("x0_busy", 128'(busy4), 128'h0);

        // Fill x1..x4, then read through all four ports.
        for (int i = 1; i <= 4; i++) begin
            w_en = 1'b1; w_addr = 5'(i); w_dat = 32'(i * 32'h11);
            step();
        end
        idle();
        ra = pk(5'd4, 5'd3, 5'd2, 5'd1);
        #1;
        chk("rd4_distinct", r4, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("rd2_distinct", 128'(r2), 128'({32'h22, 32'h11}));
        chk("rd4_busy", 128'(busy4), 128'h0);
        ra = pk(5'd3, 5'd3, 5'd3, 5'd3);
        #1;
        chk("rd4_same", r4, {4{32'h33}});

        // Reserve x5: operand busy, WAW blocks a second reservation.
        iss_en = 1'b1; iss_addr = 5'd5;
        #1;
        chk("x5_rdy_before", 128'(rdy4), 128'h1);
        step();
        idle();
        ra = pk(5'd0, 5'd0, 5'd5, 5'd5);
        #1;
        chk("x5_busy4", 128'(busy4), 128'h3);
        chk("x5_busy2", 128'(busy2), 128'h3);
        chk("x5_rdy4", 128'(rdy4), 128'h0);
        chk("x5_rdy2", 128'(rdy2), 128'h0);
        chk("x5_old", 128'(r4[31:0]), 128'h0);

        // Writeback of x5 while reading it.
        w_en = 1'b1; w_addr = 5'd5; w_dat = 32'h1234;
        #1;
        chk("x5_byp_rd", 128'(r4[63:0]), 128'({32'h1234, 32'h1234}));
        chk("x5_byp_busy", 128'(busy4), 128'h0);
        chk("x5_nobyp_rd", 128'(r2[31:0]), 128'h0);
        chk("x5_nobyp_busy", 128'(busy2), 128'h3);
        chk("x5_wb_rdy", 128'(rdy4), 128'h1);
        step();
        idle();
        #1;
        chk("x5_after_rd4", 128'(r4[31:0]), 128'h1234);
        chk("x5_after_busy4", 128'(busy4), 128'h0);
        chk("x5_after_rd2", 128'(r2[31:0]), 128'h1234);
        chk("x5_after_busy2", 128'(busy2), 128'h0);
        chk("x5_after_rdy", 128'(rdy4), 128'h1);

        // x7: pending, then write and re-reserve in the same cycle.
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        #1;
        chk("x7_waw_rdy", 128'(rdy4), 128'h0);
        step();
        w_en = 1'b1; w_addr = 5'd7; w_dat = 32'h77;
        #1;
        chk("x7_wr_iss_rdy", 128'(rdy4), 128'h1);
        step();
        idle();
        ra = pk(5'd0, 5'd0, 5'd0, 5'd7);
        #1;
        chk("x7_data", 128'(r4[31:0]), 128'h77);
        chk("x7_busy", 128'(busy4), 128'h1);
        chk("x7_rdy", 128'(rdy4), 128'h0);

        // Flush with x7, x8, x10 pending and a same-cycle reservation of x9.
        iss_en = 1'b1; iss_addr = 5'd8;
        step();
        iss_addr = 5'd10;
        step();
        idle();
        ra = pk(5'd9, 5'd10, 5'd8, 5'd7);
        #1;
        chk("pre_flush_busy", 128'(busy4), 128'h7);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        #1;
        chk("flush_busy4", 128'(busy4), 128'h0);
        chk("flush_busy2", 128'(busy2), 128'h0);
        chk("flush_x9_rdy", 128'(rdy4), 128'h1);
        iss_addr = 5'd7;
        #1;
        chk("flush_x7_rdy", 128'(rdy4), 128'h1);

        // Flush together with a write: data still lands.
        iss_en = 1'b1; iss_addr = 5'd11;
        step();
        idle();
        flush = 1'b1; w_en = 1'b1; w_addr = 5'd11; w_dat = 32'hBB;
        step();
        idle();
        ra = pk(5'd0, 5'd0, 5'd0, 5'd11);
        #1;
        chk("flush_wr_data", 128'(r4[31:0]), 128'hBB);
        chk("flush_wr_busy", 128'(busy4), 128'h0);

        // Write to a non-pending register.
        w_en = 1'b1; w_addr = 5'd6; w_dat = 32'h66;
        step();
        idle();
        ra = pk(5'd0, 5'd0, 5'd0, 5'd6);
        #1;
        chk("nonpend_data", 128'(r2[31:0]), 128'h66);
        chk("nonpend_busy", 128'(busy2), 128'h0);

        // Asynchronous reset mid-operation drops reservations and data at once.
        iss_en = 1'b1; iss_addr = 5'd12;
        step();
        idle();
        ra = pk(5'd1, 5'd2, 5'd3, 5'd12);
        #1;
        chk("pre_arst_busy", 128'(busy4), 128'h1);
        rst = 1'b0;
        w_en = 1'b1; w_addr = 5'd12; w_dat = 32'hFF;
        #1;
        chk("arst_rd", r4, 128'h0);
        chk("arst_busy", 128'(busy4), 128'h0);
        chk("arst_rdy", 128'(rdy4), 128'h1);
        idle();
        rst = 1'b1;
        #1;
        step();
        chk("post_arst_rd", r4, 128'h0);
        chk("post_arst_busy", 128'(busy4), 128'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
